// File: rtl/la_pkg.sv
// Shared types and helpers for the logic analyzer trigger stages.
// Holds the UART receiver state encoding and the masked byte compare.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int MIN_BAUD = 4;

  // Mask bit set means that bit position is ignored.
  function automatic logic masked_eq(
    input logic [7:0] data,
    input logic [7:0] match,
    input logic [7:0] mask
  );
    return ((data ^ match) & ~mask) == 8'h00;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous input line.
// STAGES must be 2 or more; clr forces every flop to RST_VAL.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the line through the flop chain.
  always_ff @(posedge clk) begin
    if (clr) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_prot_trig.sv
// UART 8N1 receiver with masked byte-match trigger pulse.
// Samples each bit at its centre, counted from the synced start edge.
module uart_prot_trig
  import la_pkg::*;
#(
  parameter int BAUD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  input  logic [BAUD_W-1:0] baud_cnt,
  input  logic [7:0]        match,
  input  logic [7:0]        mask,
  input  logic              en,
  output logic              byte_vld,
  output logic [7:0]        rx_byte,
  output logic              UARTtrig,
  output logic              frm_err
);

  uart_rx_state_t    state, nxt;
  logic              clr;
  logic              rx_s, rx_s_prev;
  logic              fall, tick;
  logic [BAUD_W-1:0] baud_eff;
  logic [BAUD_W-1:0] half_m1, full_m1;
  logic [BAUD_W-1:0] cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        sh;
  logic              ld_half, ld_full, dec;
  logic              shift, bits_clr;
  logic              done_ok, done_err;

  assign clr = rst | ~en;

  bit_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .clr(clr),
    .d  (RX),
    .q  (rx_s)
  );

  // Previous synced level for start-edge detection.
  always_ff @(posedge clk) begin
    if (clr) rx_s_prev <= 1'b1;
    else     rx_s_prev <= rx_s;
  end

  assign fall = rx_s_prev & ~rx_s;
  assign tick = (cnt == '0);

  assign baud_eff = (baud_cnt < BAUD_W'(MIN_BAUD))
                  ? BAUD_W'(MIN_BAUD) : baud_cnt;
  // Counters reload one short so a sample lands exactly
  // half a bit, then whole bits, after the start edge.
  assign half_m1  = (baud_eff >> 1) - BAUD_W'(1);
  assign full_m1  = baud_eff - BAUD_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (fall) nxt = START;
      START: if (tick) nxt = rx_s ? IDLE : DATA;
      DATA:  if (tick && bit_cnt == 3'd7) nxt = STOP;
      STOP:  if (tick) nxt = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath strobes per state.
  always_comb begin
    ld_half  = 1'b0;
    ld_full  = 1'b0;
    dec      = 1'b0;
    shift    = 1'b0;
    bits_clr = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    unique case (state)
      IDLE:  ld_half = fall;
      START: begin
        if (!tick) dec = 1'b1;
        else if (!rx_s) begin
          ld_full  = 1'b1;
          bits_clr = 1'b1;
        end
      end
      DATA: begin
        if (!tick) dec = 1'b1;
        else begin
          shift   = 1'b1;
          ld_full = 1'b1;
        end
      end
      STOP: begin
        if (!tick) dec = 1'b1;
        else begin
          done_ok  = rx_s;
          done_err = ~rx_s;
        end
      end
      default: ;
    endcase
  end

  // Counters, shift register and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      rx_byte  <= '0;
      byte_vld <= 1'b0;
      UARTtrig <= 1'b0;
      frm_err  <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_vld <= 1'b0;
      UARTtrig <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      byte_vld <= done_ok;
      UARTtrig <= done_ok & masked_eq(sh, match, mask);
      frm_err  <= done_err;
      if (done_ok) rx_byte <= sh;
      if (ld_half)      cnt <= half_m1;
      else if (ld_full) cnt <= full_m1;
      else if (dec)     cnt <= cnt - BAUD_W'(1);
      if (bits_clr)   bit_cnt <= '0;
      else if (shift) bit_cnt <= bit_cnt + 3'd1;
      if (shift) sh <= {rx_s, sh[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_prot_trig.sv
// Randomized bench for uart_prot_trig with a line-history model.
// Directed scenarios pin literal byte and pulse counts.
module tb_uart_prot_trig;

  localparam int BW = 16;
  localparam int SS = 2;
  localparam int N  = 131072;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RX  = 1'b1;
  logic          en  = 1'b1;
  logic [BW-1:0] baud = 16;
  logic [7:0]    match = 8'h00;
  logic [7:0]    mask  = 8'h00;
  logic          byte_vld, UARTtrig, frm_err;
  logic [7:0]    rx_byte;

  uart_prot_trig #(.BAUD_W(BW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .RX(RX), .baud_cnt(baud),
    .match(match), .mask(mask), .en(en),
    .byte_vld(byte_vld), .rx_byte(rx_byte),
    .UARTtrig(UARTtrig), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit r_h[N];
  bit c_h[N];
  bit hs[N];
  int p = 0;

  bit         busy = 0, brk = 0;
  int         e = 0;
  logic [7:0] exp_byte = 8'h00;
  bit         e_vld, e_trig, e_err;
  int         n_vld = 0, n_trig = 0, n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic int eff_of(input logic [BW-1:0] b);
    return (b < 4) ? 4 : int'(b);
  endfunction

  // Model: rebuild the synced line, then decode frames from history.
  always @(posedge clk) begin
    bit         any, cur, prev;
    int         c, off, ef, hf;
    logic [7:0] b;
    p++;
    e_vld = 0; e_trig = 0; e_err = 0;
    if (p < N - 1) begin
      r_h[p] = RX;
      c_h[p] = rst | ~en;
      any = 0;
      for (int i = 0; i < SS; i++)
        if (p - i < 1 || c_h[p-i]) any = 1;
      hs[p] = any ? 1'b1 : r_h[p-SS+1];
      ef = eff_of(baud);
      hf = ef / 2;
      if (c_h[p]) begin
        busy = 0; brk = 0;
        if (rst) exp_byte = 8'h00;
      end else if (p >= 3) begin
        c    = p - 1;
        cur  = hs[c];
        prev = c_h[c] ? 1'b1 : hs[c-1];
        if (brk) begin
          if (cur) brk = 0;
        end else if (busy) begin
          off = c - e;
          if (off == hf && cur) busy = 0;
          else if (off == hf + 9 * ef) begin
            busy = 0;
            if (cur) begin
              for (int n = 1; n <= 8; n++)
                b[n-1] = hs[e + hf + n * ef];
              e_vld    = 1;
              e_trig   = (((b ^ match) & ~mask) == 8'h00);
              exp_byte = b;
            end else begin
              e_err = 1;
              brk   = 1;
            end
          end
        end else if (prev && !cur) begin
          busy = 1;
          e    = c;
        end
      end
    end
    #1;
    chk("byte_vld", {7'd0, byte_vld}, {7'd0, e_vld});
    chk("UARTtrig", {7'd0, UARTtrig}, {7'd0, e_trig});
    chk("frm_err", {7'd0, frm_err}, {7'd0, e_err});
    chk("rx_byte", rx_byte, exp_byte);
    if (byte_vld) n_vld++;
    if (UARTtrig) n_trig++;
    if (frm_err)  n_err++;
  end

  task automatic drive(input logic v, input int n);
    RX = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    int ef;
    ef = eff_of(baud);
    drive(1'b0, ef);
    for (int i = 0; i < 8; i++) drive(b[i], ef);
    drive(stop_ok, ef);
  endtask

  int v0, t0, f0;

  task automatic snap();
    v0 = n_vld; t0 = n_trig; f0 = n_err;
  endtask

  initial begin
    logic [7:0] rb;
    int         k;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 20);

    match = 8'h96; mask = 8'h00; snap();
    send(8'h96, 1); drive(1'b1, 20);
    chk("t1 byte", rx_byte, 8'h96);
    chk("t1 model", exp_byte, 8'h96);
    chk_i("t1 vld", n_vld - v0, 1);
    chk_i("t1 trig", n_trig - t0, 1);
    chk_i("t1 err", n_err - f0, 0);

    match = 8'h90; mask = 8'h0F; snap();
    send(8'h96, 1); send(8'hA6, 1); drive(1'b1, 20);
    chk_i("t2 vld", n_vld - v0, 2);
    chk_i("t2 trig", n_trig - t0, 1);
    chk("t2 byte", rx_byte, 8'hA6);

    snap();
    drive(1'b0, 5); drive(1'b1, 40);
    chk_i("t3 false", n_vld - v0, 0);
    send(8'h55, 1); drive(1'b1, 20);
    chk_i("t3 vld", n_vld - v0, 1);
    chk("t3 byte", rx_byte, 8'h55);

    match = 8'h96; mask = 8'h00; snap();
    send(8'h3C, 0); drive(1'b0, 40);
    chk_i("t4 err", n_err - f0, 1);
    chk_i("t4 brk vld", n_vld - v0, 0);
    chk_i("t4 brk trig", n_trig - t0, 0);
    drive(1'b1, 20);
    send(8'h96, 1); drive(1'b1, 20);
    chk_i("t4 vld", n_vld - v0, 1);
    chk_i("t4 trig", n_trig - t0, 1);
    chk("t4 byte", rx_byte, 8'h96);

    baud = 868; drive(1'b1, 20); snap();
    send(8'h01, 1); send(8'h96, 1); send(8'hFF, 1);
    drive(1'b1, 900);
    chk_i("t5 vld", n_vld - v0, 3);
    chk_i("t5 trig", n_trig - t0, 1);
    chk("t5 byte", rx_byte, 8'hFF);

    baud = 16; drive(1'b1, 40); snap();
    drive(1'b0, 16); drive(1'b0, 16); drive(1'b1, 8);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    drive(1'b1, 200);
    chk_i("t6 vld", n_vld - v0, 0);
    chk("t6 byte", rx_byte, 8'h00);
    send(8'h96, 1); drive(1'b1, 20);
    chk_i("t6 vld2", n_vld - v0, 1);
    chk("t6 byte2", rx_byte, 8'h96);

    baud = 1; drive(1'b1, 20);
    send(8'h5A, 1); drive(1'b1, 10);
    chk("min baud", rx_byte, 8'h5A);

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        drive(1'b1, 60);
        baud = BW'($urandom_range(0, 24));
        drive(1'b1, 60);
      end
      rb = 8'($urandom);
      k  = $urandom_range(0, 3);
      match = (k == 0) ? rb : 8'($urandom);
      mask  = (k == 1) ? 8'hFF : (k == 2) ? 8'h00 : 8'($urandom);
      k = $urandom_range(0, 19);
      if (k == 0) begin
        drive(1'b0, $urandom_range(1, 3));
        drive(1'b1, 60);
      end else if (k == 1) begin
        drive(1'b0, eff_of(baud) * 3);
        en = 1'b0; drive(1'b1, 3); en = 1'b1;
        drive(1'b1, 60);
      end else if (k == 2) begin
        send(rb, 0);
        drive(1'b0, $urandom_range(0, 30));
        drive(1'b1, $urandom_range(1, 10));
      end else begin
        send(rb, 1);
        drive(1'b1, $urandom_range(0, 30));
      end
    end
    drive(1'b1, 100);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
